// File: rtl/lock_water_ctrl.sv
// lock_water_ctrl
// Water-level sequencer for the lock chamber. A single-cycle fill/drain request
// taken in IDLE starts a timed ramp of the chamber level, one unit every
// STEP_CYCLES clocks. The ramp is interlocked against both door-closed lines:
// a door opening mid-ramp freezes the level and parks the block in FAULT until
// fault_clr is given with both doors closed.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   fill_req    fill request (sampled in IDLE only)
//   drain_req   drain request (sampled in IDLE only)
//   in_closed   inner door closed
//   out_closed  outer door closed
//   fault_clr   leave FAULT (needs both doors closed)
//   level       registered chamber level, 0..LEVEL_MAX
//   full/empty  decodes of level
//   busy        FILLING or DRAINING
//   done        one-cycle pulse on ramp completion
//   fault       in FAULT
//
// state    | meaning
// IDLE     | waiting for a request
// FILLING  | level ramping up
// DRAINING | level ramping down
// FAULT    | door opened mid-ramp, level frozen
module lock_water_ctrl #(
  parameter int LEVEL_MAX   = 8,
  parameter int STEP_CYCLES = 4,
  parameter int LEVEL_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fill_req,
  input  logic               drain_req,
  input  logic               in_closed,
  input  logic               out_closed,
  input  logic               fault_clr,
  output logic [LEVEL_W-1:0] level,
  output logic               full,
  output logic               empty,
  output logic               busy,
  output logic               done,
  output logic               fault
);

  localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PW-1:0]      PRESC_LAST = PW'(STEP_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LVL_MAX    = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] LVL_ONE    = LEVEL_W'(1);

  typedef enum logic [1:0] {IDLE, FILLING, DRAINING, FAULT} state_t;

  state_t             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic               done_q, done_d;
  logic               doors_ok;

  assign doors_ok = in_closed & out_closed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      level_q <= '0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Prescaler held at 0 here so every ramp starts from a clean count.
        presc_d = '0;
        if (fill_req && !drain_req && doors_ok && (level_q < LVL_MAX))
          state_d = FILLING;
        else if (drain_req && !fill_req && doors_ok && (level_q != '0))
          state_d = DRAINING;
      end
      FILLING, DRAINING: begin
        if (!doors_ok) begin
          // Interlock wins over a step falling on the same edge.
          state_d = FAULT;
          presc_d = '0;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (state_q == FILLING) begin
            if (level_q < LVL_MAX) level_d = level_q + LVL_ONE;
            if (level_q >= LVL_MAX - LVL_ONE) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            if (level_q != '0) level_d = level_q - LVL_ONE;
            if (level_q <= LVL_ONE) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      FAULT: begin
        presc_d = '0;
        if (fault_clr && doors_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign level = level_q;
  assign full  = (level_q == LVL_MAX);
  assign empty = (level_q == '0);
  assign busy  = (state_q == FILLING) || (state_q == DRAINING);
  assign fault = (state_q == FAULT);
  assign done  = done_q;

endmodule

// File: tb/tb_lock_water_ctrl.sv
module tb_lock_water_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       fill_req, drain_req, in_closed, out_closed, fault_clr;
  logic [3:0] level;
  logic       full, empty, busy, done, fault;

  logic       fill2;
  logic [1:0] level2;
  logic       full2, empty2, busy2, done2, fault2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int lvl;
    bit dn;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  lock_water_ctrl #(.LEVEL_MAX(8), .STEP_CYCLES(4), .LEVEL_W(4)) dut (
    .clk(clk), .rst(rst), .fill_req(fill_req), .drain_req(drain_req),
    .in_closed(in_closed), .out_closed(out_closed), .fault_clr(fault_clr),
    .level(level), .full(full), .empty(empty), .busy(busy), .done(done),
    .fault(fault)
  );

  lock_water_ctrl #(.LEVEL_MAX(3), .STEP_CYCLES(1), .LEVEL_W(2)) dut2 (
    .clk(clk), .rst(rst), .fill_req(fill2), .drain_req(1'b0),
    .in_closed(1'b1), .out_closed(1'b1), .fault_clr(1'b0),
    .level(level2), .full(full2), .empty(empty2), .busy(busy2), .done(done2),
    .fault(fault2)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Push the expected level sequence, then pop one entry per step and compare.
  // Each step is also checked one cycle early to catch a wrong step period.
  task automatic ramp(input string tag, input int start, input int stop, input int dir);
    exp_t e;
    int   final_lvl;
    final_lvl = (dir > 0) ? 8 : 0;
    for (int l = start + dir; l != stop + dir; l += dir)
      sb.push_back('{lvl: l, dn: (l == final_lvl)});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tick(3);
      chk({tag, "_pre"}, int'(level), e.lvl - dir);
      chk({tag, "_predone"}, int'(done), 0);
      tick(1);
      chk({tag, "_lvl"}, int'(level), e.lvl);
      chk({tag, "_done"}, int'(done), int'(e.dn));
      chk({tag, "_busy"}, int'(busy), e.dn ? 0 : 1);
    end
  endtask

  task automatic request(input string tag, input bit f, input bit d);
    fill_req  = f;
    drain_req = d;
    tick(1);
    fill_req  = 1'b0;
    drain_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    fill_req = 0; drain_req = 0; in_closed = 1; out_closed = 1; fault_clr = 0;
    fill2 = 0;
    tick(2);
    rst = 1'b0;
    tick(1);

    chk("rst_level", int'(level), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fault", int'(fault), 0);

    // Full fill 0 -> 8
    request("fill", 1, 0);
    chk("fill_busy0", int'(busy), 1);
    ramp("fill", 0, 8, 1);
    chk("fill_full", int'(full), 1);
    tick(1);
    chk("fill_done_clr", int'(done), 0);
    chk("fill_idle", int'(busy), 0);

    // Full drain 8 -> 0
    request("drain", 0, 1);
    chk("drain_busy0", int'(busy), 1);
    ramp("drain", 8, 0, -1);
    chk("drain_empty", int'(empty), 1);
    tick(1);
    chk("drain_done_clr", int'(done), 0);

    // Interlock: fill to 3, open the outer door
    request("ffill", 1, 0);
    ramp("ffill", 0, 3, 1);
    out_closed = 1'b0;
    tick(1);
    chk("flt_fault", int'(fault), 1);
    chk("flt_busy", int'(busy), 0);
    chk("flt_level", int'(level), 3);
    for (int i = 0; i < 20; i++) begin
      fill_req = i[0];
      tick(1);
      chk("flt_hold", int'(level), 3);
      chk("flt_stay", int'(fault), 1);
    end
    fill_req  = 1'b0;
    fault_clr = 1'b1;
    tick(1);
    chk("flt_clr_open", int'(fault), 1);
    out_closed = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    chk("flt_clr_fault", int'(fault), 0);
    chk("flt_clr_level", int'(level), 3);
    chk("flt_clr_done", int'(done), 0);
    chk("flt_clr_busy", int'(busy), 0);
    request("rfill", 1, 0);
    chk("rfill_busy0", int'(busy), 1);
    ramp("rfill", 3, 8, 1);

    // Boundary requests at level 8
    tick(1);
    request("both", 1, 1);
    chk("both_busy", int'(busy), 0);
    tick(4);
    chk("both_level", int'(level), 8);
    request("fill_full", 1, 0);
    chk("fullreq_busy", int'(busy), 0);
    chk("fullreq_done", int'(done), 0);
    in_closed = 1'b0;
    request("drain_open", 0, 1);
    chk("dopen_busy", int'(busy), 0);
    chk("dopen_fault", int'(fault), 0);
    in_closed = 1'b1;

    // Empty, then boundary requests at level 0
    request("drain2", 0, 1);
    ramp("drain2", 8, 0, -1);
    tick(1);
    request("drain_empty", 0, 1);
    chk("emptyreq_busy", int'(busy), 0);
    chk("emptyreq_done", int'(done), 0);
    in_closed = 1'b0;
    request("fill_open", 1, 0);
    chk("fopen_busy", int'(busy), 0);
    chk("fopen_fault", int'(fault), 0);
    tick(2);
    chk("fopen_level", int'(level), 0);
    in_closed = 1'b1;

    // Reset mid-fill at level 5
    request("mfill", 1, 0);
    ramp("mfill", 0, 5, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mrst_level", int'(level), 0);
    chk("mrst_empty", int'(empty), 1);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_fault", int'(fault), 0);
    chk("mrst_done", int'(done), 0);
    tick(6);
    chk("mrst_stay", int'(level), 0);

    // Variant LEVEL_MAX=3, STEP_CYCLES=1
    fill2 = 1'b1;
    tick(1);
    fill2 = 1'b0;
    chk("v_busy0", int'(busy2), 1);
    chk("v_lvl0", int'(level2), 0);
    for (int l = 1; l <= 3; l++) sb.push_back('{lvl: l, dn: (l == 3)});
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      tick(1);
      chk("v_lvl", int'(level2), e.lvl);
      chk("v_done", int'(done2), int'(e.dn));
    end
    chk("v_full", int'(full2), 1);
    tick(1);
    chk("v_done_clr", int'(done2), 0);
    chk("v_busy_end", int'(busy2), 0);
    chk("v_fault", int'(fault2), 0);
    chk("v_empty", int'(empty2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lock_water_ctrl.md
Name: lock_water_ctrl

Overview:
Water-level sequencer for the lock chamber. Turns single-cycle fill/drain requests from the lock controller into a timed level ramp, interlocked against the door-closed status lines. Sits directly upstream of the lock controller and supplies its chamber full/empty status. The lock controller issues fill_req/drain_req; this block reports level, full, empty, busy, done and fault.

Parameters:
LEVEL_MAX, 8, chamber level in units when completely full (level range 0..LEVEL_MAX).
STEP_CYCLES, 4, clock cycles per one-unit level change (must be >= 1).
LEVEL_W, 4, width of the level output (must satisfy 2^LEVEL_W > LEVEL_MAX).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
fill_req  input  1  request to fill the chamber; sampled only in IDLE.
drain_req  input  1  request to drain the chamber; sampled only in IDLE.
in_closed  input  1  inner door closed (1 = closed).
out_closed  input  1  outer door closed (1 = closed).
fault_clr  input  1  clears FAULT when both doors are closed.
level  output  LEVEL_W  current water level, registered.
full  output  1  level == LEVEL_MAX.
empty  output  1  level == 0.
busy  output  1  high in FILLING or DRAINING.
done  output  1  one-cycle pulse when a fill or drain completes.
fault  output  1  high in FAULT.

Behaviour:
- Reset: state IDLE, level 0, prescaler 0, done 0, fault 0, busy 0. Outputs are full=0 and empty=1. Reset takes priority over all other inputs in any state, including mid-ramp.
- The FSM has four states: IDLE, FILLING, DRAINING, FAULT.
- doors_ok = in_closed & out_closed.
- IDLE transitions:
  - fill_req & ~drain_req & doors_ok & level<LEVEL_MAX -> FILLING.
  - drain_req & ~fill_req & doors_ok & level>0 -> DRAINING.
  - Both requests high -> ignored, stay IDLE.
  - A request while doors are not closed, or fill when full, or drain when empty -> ignored, no fault, no done.
- On entry to FILLING or DRAINING the prescaler loads 0.
- Prescaler behaviour while in FILLING or DRAINING:
  - The prescaler counts every cycle.
  - On the edge where prescaler == STEP_CYCLES-1, level moves by ±1 and the prescaler wraps to 0.
  - The first level change occurs STEP_CYCLES edges after the request edge.
- Completion:
  - The edge that writes level = LEVEL_MAX (FILLING) or level = 0 (DRAINING) also moves the state to IDLE and sets done=1.
  - done clears on the next edge, so it is exactly 1 cycle wide.
  - A full fill from 0 takes LEVEL_MAX*STEP_CYCLES cycles.
- fill_req and drain_req are ignored while busy; no reversal or restart.
- Interlock:
  - If doors_ok is low on any edge in FILLING or DRAINING, the state goes to FAULT on that edge.
  - level freezes at its current value, the prescaler clears, and no level step occurs on that edge.
- FAULT exit:
  - fault_clr & doors_ok -> IDLE. level keeps its partial value; done is not asserted.
  - fault_clr with doors open is ignored. Requests are ignored in FAULT.
- Level arithmetic never wraps: level stays within 0..LEVEL_MAX under all input sequences.
- full and empty are combinational decodes of the registered level. busy and fault are decodes of the registered state.

Test Plan:
- Defaults, doors closed, level 0, one-cycle fill_req at edge N:
  - busy=1 from N.
  - level=1 at N+4, 2 at N+8, …, 8 at N+32.
  - At N+32: full=1, busy=0, done=1 for exactly one cycle.
- From full, drain_req: level steps 8→0 every 4 cycles. empty=1 and one done pulse at request+32.
- Fill from 0, then drop out_closed just after level reaches 3:
  - fault=1, busy=0, level stays 3 for 20 cycles even with fill_req toggling.
  - fault_clr with out_closed=0 -> no change.
  - fault_clr with out_closed=1 -> IDLE, level 3, no done.
  - A following fill_req completes to 8 in 20 cycles.
- Boundary requests: fill_req and drain_req together in IDLE -> no state change. fill_req at level 8 -> no busy, no done. drain_req at level 0 -> none. fill_req with in_closed=0 -> ignored, fault stays 0.
- Assert rst for one cycle at level 5 mid-fill -> next cycle level=0, empty=1, busy=0, fault=0, done=0.
- Parameter variant LEVEL_MAX=3, STEP_CYCLES=1: full fill completes in 3 cycles with level 1,2,3 on consecutive edges and a single done pulse.
